// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-stage access controller.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam int WORD_LEN_DEFAULT = 16;
    localparam int ADDR_LEN_DEFAULT = 16;
    localparam int TIMEOUT_DEFAULT  = 16;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory port bundle between the memory-stage controller (master) and the memory (slave).
interface mem_stage_ctrl_if #(
    parameter int WORD_LEN = 16,
    parameter int ADDR_LEN = 16
);
    // Handshake: the master raises mem_req with mem_we/mem_addr/mem_wdata and holds all four
    // stable until mem_ack is sampled high at a rising edge; mem_rdata is valid with mem_ack.
    // mem_ack is ignored while mem_req is low. A mem_req that drops without an ack is an abort.
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_LEN-1:0] mem_addr;
    logic [WORD_LEN-1:0] mem_wdata;
    logic                mem_ack;
    logic [WORD_LEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_timeout_ctr.sv
// Loadable saturating up-counter with clear, enable and a terminal-count flag at TIMEOUT-1.
module mem_timeout_ctr #(
    parameter int TIMEOUT = 16,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_TC  = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Saturates instead of wrapping so a stuck enable can never re-arm the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == CNT_TC);
endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage access controller: turns a pending load/store into a req/ack transaction,
// stalls the pipeline while waiting, and pulses the result towards MEM/WB for one cycle.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int WORD_LEN = WORD_LEN_DEFAULT,
    parameter int ADDR_LEN = ADDR_LEN_DEFAULT,
    parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           PR3_MEM_read,
    input  logic                           PR3_MEM_write,
    input  logic [WORD_LEN-1:0]            PR3_alu_out,
    input  logic [WORD_LEN-1:0]            PR3_store_data,
    mem_stage_ctrl_if.master               mem,
    output logic                           stall,
    output logic [WORD_LEN-1:0]            MEM_out,
    output logic                           MEM_valid,
    output logic                           mem_err,
    output mem_state_t                     o_dbg_state,
    output logic [$clog2(TIMEOUT+1)-1:0]   o_dbg_count
);
    localparam int CW = $clog2(TIMEOUT + 1);

    mem_state_t          r_state;
    mem_state_t          w_next;
    logic                r_req;
    logic                r_we;
    logic [ADDR_LEN-1:0] r_addr;
    logic [WORD_LEN-1:0] r_wdata;
    logic [WORD_LEN-1:0] r_out;
    logic                r_err;
    logic                w_access;
    logic                w_start;
    logic                w_ctr_en;
    logic                w_tc;
    logic [CW-1:0]       w_count;

    assign w_access = PR3_MEM_read | PR3_MEM_write;

    mem_timeout_ctr #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_timeout_ctr (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_start),
        .i_en       (w_ctr_en),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_count    (w_count),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_ctr_en = 1'b0;
        stall    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access) begin
                    w_next  = WAIT;
                    w_start = 1'b1;
                    stall   = 1'b1;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (mem.mem_ack) begin
                    w_next = DONE;
                end else begin
                    w_ctr_en = 1'b1;
                    if (w_tc) begin
                        w_next = DONE;
                    end
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // A store's write-enable wins when both read and write are flagged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_out   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        r_req   <= 1'b1;
                        r_we    <= PR3_MEM_write;
                        r_addr  <= PR3_alu_out[ADDR_LEN-1:0];
                        r_wdata <= PR3_store_data;
                        r_err   <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem.mem_ack) begin
                        r_req <= 1'b0;
                        if (!r_we) begin
                            r_out <= mem.mem_rdata;
                        end
                    end else if (w_tc) begin
                        r_req <= 1'b0;
                        r_out <= '0;
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_req   = r_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;
    assign MEM_out       = r_out;
    assign MEM_valid     = (r_state == DONE);
    assign mem_err       = (r_state == DONE) & r_err;
    assign o_dbg_state   = r_state;
    assign o_dbg_count   = w_count;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with TIMEOUT = 4: vector table plus hand-written corner sequences.
module tb_mem_stage_ctrl;
    import mem_stage_pkg::*;

    localparam int WL = 16;
    localparam int AL = 16;
    localparam int TO = 4;
    localparam int CW = $clog2(TO + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd  = 1'b0;
    logic          wr  = 1'b0;
    logic [WL-1:0] alu = '0;
    logic [WL-1:0] sd  = '0;
    logic          stall;
    logic [WL-1:0] mem_out;
    logic          mem_valid;
    logic          mem_err;
    mem_state_t    dbg_state;
    logic [CW-1:0] dbg_count;

    int checks   = 0;
    int failures = 0;

    mem_stage_ctrl_if #(.WORD_LEN(WL), .ADDR_LEN(AL)) mif ();

    mem_stage_ctrl #(
        .WORD_LEN (WL),
        .ADDR_LEN (AL),
        .TIMEOUT  (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PR3_MEM_read   (rd),
        .PR3_MEM_write  (wr),
        .PR3_alu_out    (alu),
        .PR3_store_data (sd),
        .mem            (mif),
        .stall          (stall),
        .MEM_out        (mem_out),
        .MEM_valid      (mem_valid),
        .mem_err        (mem_err),
        .o_dbg_state    (dbg_state),
        .o_dbg_count    (dbg_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ack_wait: ack in the Nth WAIT cycle; 0 means the memory never answers.
    typedef struct {
        logic          rd;
        logic          wr;
        logic [WL-1:0] addr;
        logic [WL-1:0] data;
        int            ack_wait;
        logic [WL-1:0] rdata;
        int            exp_stall;
        int            exp_req;
        logic [WL-1:0] exp_out;
        logic          exp_err;
        logic          exp_we;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v, input int idx);
        int            stall_n  = 0;
        int            req_n    = 0;
        int            cyc      = 0;
        logic          done     = 1'b0;
        logic          unstable = 1'b0;
        logic [WL-1:0] out_v    = '0;
        logic          err_v    = 1'b0;
        logic          req_v    = 1'b1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (cyc == 0) begin
                rd  = v.rd;
                wr  = v.wr;
                alu = v.addr;
                sd  = v.data;
            end
            if (mif.mem_req) begin
                req_n++;
                if (mif.mem_we !== v.exp_we || mif.mem_addr !== v.addr || mif.mem_wdata !== v.data)
                    unstable = 1'b1;
                mif.mem_ack   = (req_n == v.ack_wait);
                mif.mem_rdata = mif.mem_ack ? v.rdata : WL'($urandom);
            end else begin
                mif.mem_ack = 1'b0;
            end
            #1;
            if (stall) stall_n++;
            if (mem_valid) begin
                done  = 1'b1;
                out_v = mem_out;
                err_v = mem_err;
                req_v = mif.mem_req;
                rd    = 1'b0;
                wr    = 1'b0;
            end
            cyc++;
        end
        mif.mem_ack = 1'b0;
        check($sformatf("v%0d_done", idx), 32'(done), 32'd1);
        check($sformatf("v%0d_stall_cycles", idx), 32'(stall_n), 32'(v.exp_stall));
        check($sformatf("v%0d_req_cycles", idx), 32'(req_n), 32'(v.exp_req));
        check($sformatf("v%0d_req_fields_stable", idx), 32'(unstable), 32'd0);
        check($sformatf("v%0d_mem_out", idx), 32'(out_v), 32'(v.exp_out));
        check($sformatf("v%0d_mem_err", idx), 32'(err_v), 32'(v.exp_err));
        check($sformatf("v%0d_req_low_in_done", idx), 32'(req_v), 32'd0);
    endtask

    initial begin
        logic [5:0] stall_pat;
        logic [5:0] valid_pat;
        logic       bad;

        vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1, 16'hBEEF, 2, 1, 16'hBEEF, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 16'h0012, 16'h1234, 3, 16'hDEAD, 4, 3, 16'hBEEF, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 0, 16'h0000, 5, 4, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 16'h0020, 16'h5555, 2, 16'h7777, 3, 2, 16'h0000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 4, 16'hA5A5, 5, 4, 16'hA5A5, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 2, 16'h0F0F, 3, 2, 16'h0F0F, 1'b0, 1'b0};

        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;

        // Clock and reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        check("rst_count", 32'(dbg_count), 32'd0);
        check("rst_mem_req", 32'(mif.mem_req), 32'd0);
        check("rst_mem_we", 32'(mif.mem_we), 32'd0);
        check("rst_mem_addr", 32'(mif.mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mif.mem_wdata), 32'd0);
        check("rst_mem_out", 32'(mem_out), 32'd0);
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);

        // Non-memory instructions: no stall, no request
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            alu = WL'($urandom);
            sd  = WL'($urandom);
            #1;
            if (stall || mif.mem_req || mem_valid) bad = 1'b1;
        end
        check("nonmem_no_activity", 32'(bad), 32'd0);

        // Spurious ack while idle
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mif.mem_ack   = (i < 2);
            mif.mem_rdata = 16'h9999;
            #1;
            if (dbg_state != IDLE || mif.mem_req || mem_valid || mem_err) bad = 1'b1;
        end
        check("idle_ack_ignored", 32'(bad), 32'd0);
        check("idle_ack_out_unchanged", 32'(mem_out), 32'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Back-to-back loads: one stall-free DONE cycle between requests
        stall_pat = '0;
        valid_pat = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rd  = 1'b1;
                alu = 16'h0300;
            end
            mif.mem_ack   = mif.mem_req;
            mif.mem_rdata = 16'hC3C3;
            #1;
            stall_pat[i] = stall;
            valid_pat[i] = mem_valid;
            if (i == 5) rd = 1'b0;
        end
        mif.mem_ack = 1'b0;
        check("b2b_stall_pattern", 32'(stall_pat), 32'(6'b011011));
        check("b2b_valid_pattern", 32'(valid_pat), 32'(6'b100100));
        check("b2b_mem_out", 32'(mem_out), 32'h0000C3C3);

        // Reset asserted mid-access
        @(negedge clk);
        rd  = 1'b1;
        alu = 16'h0055;
        repeat (2) @(negedge clk);
        #1;
        check("midrst_in_wait", 32'(dbg_state), 32'(WAIT));
        check("midrst_req_before", 32'(mif.mem_req), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        rd  = 1'b0;
        #1;
        check("midrst_req_dropped", 32'(mif.mem_req), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'(IDLE));
        check("midrst_addr", 32'(mif.mem_addr), 32'd0);
        check("midrst_mem_out", 32'(mem_out), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (mem_valid || mem_err || mif.mem_req || dbg_state != IDLE) bad = 1'b1;
        end
        check("midrst_no_valid_after", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
